// File: rtl/spoc_postprocessor.sv
// Output stage of the SpoC-64 LWC core: merges header FIFO words, core data/tag words and the
// decrypt verdict into the public do stream. Optional build macro SPOC_PP_MASK_EN zeroes invalid
// bytes of the last data word.
module spoc_postprocessor (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] bdo,
  input  logic        bdo_valid,
  output logic        bdo_ready,
  input  logic [3:0]  bdo_valid_bytes,
  input  logic        end_of_block,
  input  logic        msg_auth,
  input  logic        msg_auth_valid,
  output logic        msg_auth_ready,
  output logic [31:0] do_data,
  output logic        do_valid,
  input  logic        do_ready,
  output logic        do_last
);

  localparam logic [3:0]  OP_ENC     = 4'b0010;
  localparam logic [3:0]  OP_DEC     = 4'b0011;
  localparam logic [31:0] TAG_HEADER = 32'h83000008;
  localparam logic [31:0] STATUS_OK  = 32'hE0000000;
  localparam logic [31:0] STATUS_BAD = 32'hF0000000;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_TAG_HDR, S_TAG, S_WAIT_AUTH, S_STATUS
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] byte_cnt_reg, byte_cnt_next;
  logic [1:0]  tag_cnt_reg, tag_cnt_next;
  logic        fail_reg, fail_next;
  logic        dec_reg, dec_next;

  logic        last_word;
  logic [31:0] data_word;

  // The remaining byte count decides the final word, so odd lengths never wrap the counter.
  assign last_word = (byte_cnt_reg <= 16'd4);

`ifdef SPOC_PP_MASK_EN
  logic [31:0] bdo_masked;
  logic        unused_inputs;

  // valid_bytes MSB is byte 0, which sits in bdo[31:24]; bit gi therefore guards bdo[8*gi +: 8].
  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign bdo_masked[8*gi +: 8] = bdo_valid_bytes[gi] ? bdo[8*gi +: 8] : 8'h00;
  end

  assign data_word     = last_word ? bdo_masked : bdo;
  assign unused_inputs = end_of_block;
`else
  logic unused_inputs;

  assign data_word     = bdo;
  assign unused_inputs = ^{end_of_block, bdo_valid_bytes};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      byte_cnt_reg <= 16'd0;
      tag_cnt_reg  <= 2'd0;
      fail_reg     <= 1'b0;
      dec_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      tag_cnt_reg  <= tag_cnt_next;
      fail_reg     <= fail_next;
      dec_reg      <= dec_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    tag_cnt_next  = tag_cnt_reg;
    fail_next     = fail_reg;
    dec_next      = dec_reg;
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          dec_next = (cmd[31:28] == OP_DEC);
          if (cmd[31:28] == OP_ENC || cmd[31:28] == OP_DEC) begin
            state_next = S_HDR;
          end else begin
            fail_next  = 1'b1;
            state_next = S_STATUS;
          end
        end
      end
      S_HDR: begin
        if (cmd_valid && do_ready) begin
          byte_cnt_next = cmd[15:0];
          if (cmd[15:0] != 16'd0) state_next = S_DATA;
          else                    state_next = dec_reg ? S_WAIT_AUTH : S_TAG_HDR;
        end
      end
      S_DATA: begin
        if (bdo_valid && do_ready) begin
          byte_cnt_next = last_word ? 16'd0 : byte_cnt_reg - 16'd4;
          if (last_word) state_next = dec_reg ? S_WAIT_AUTH : S_TAG_HDR;
        end
      end
      S_TAG_HDR: begin
        if (do_ready) begin
          tag_cnt_next = 2'd2;
          state_next   = S_TAG;
        end
      end
      S_TAG: begin
        if (bdo_valid && do_ready) begin
          tag_cnt_next = tag_cnt_reg - 2'd1;
          if (tag_cnt_reg <= 2'd1) begin
            fail_next  = 1'b0;
            state_next = S_STATUS;
          end
        end
      end
      S_WAIT_AUTH: begin
        if (msg_auth_valid) begin
          fail_next  = ~msg_auth;
          state_next = S_STATUS;
        end
      end
      S_STATUS: begin
        if (do_ready) begin
          fail_next  = 1'b0;
          dec_next   = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = 1'b0;
    bdo_ready      = 1'b0;
    msg_auth_ready = 1'b0;
    do_data        = 32'd0;
    do_valid       = 1'b0;
    do_last        = 1'b0;
    case (state_reg)
      S_IDLE: cmd_ready = 1'b1;
      S_HDR: begin
        do_data   = cmd;
        do_valid  = cmd_valid;
        cmd_ready = do_ready;
      end
      S_DATA: begin
        do_data   = data_word;
        do_valid  = bdo_valid;
        bdo_ready = do_ready;
      end
      S_TAG_HDR: begin
        do_data  = TAG_HEADER;
        do_valid = 1'b1;
      end
      S_TAG: begin
        do_data   = bdo;
        do_valid  = bdo_valid;
        bdo_ready = do_ready;
      end
      S_WAIT_AUTH: msg_auth_ready = 1'b1;
      S_STATUS: begin
        do_data  = fail_reg ? STATUS_BAD : STATUS_OK;
        do_valid = 1'b1;
        do_last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spoc_postprocessor.sv
// Directed bench for spoc_postprocessor: each operation is described by its source words and
// the do words it must produce; a bounded loop plays the sources and checks every transfer.
module tb_spoc_postprocessor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] bdo;
  logic        bdo_valid;
  logic        bdo_ready;
  logic [3:0]  bdo_valid_bytes;
  logic        end_of_block;
  logic        msg_auth;
  logic        msg_auth_valid;
  logic        msg_auth_ready;
  logic [31:0] do_data;
  logic        do_valid;
  logic        do_ready;
  logic        do_last;

  int total = 0;
  int bad   = 0;

  logic [31:0] cmd_q[4];
  logic [31:0] bdo_q[8];
  logic [3:0]  vb_q[8];
  logic [31:0] exp_q[10];
  int          nc, nb, ne, na;
  int          cycles;

`ifdef SPOC_PP_MASK_EN
  localparam logic [31:0] L5_LAST = 32'h55000000;
`else
  localparam logic [31:0] L5_LAST = 32'h55AABBCC;
`endif

  spoc_postprocessor dut (
    .clk(clk), .rst(rst),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .bdo(bdo), .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
    .bdo_valid_bytes(bdo_valid_bytes), .end_of_block(end_of_block),
    .msg_auth(msg_auth), .msg_auth_valid(msg_auth_valid), .msg_auth_ready(msg_auth_ready),
    .do_data(do_data), .do_valid(do_valid), .do_ready(do_ready), .do_last(do_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  // Plays cmd_q/bdo_q as sources and checks each do transfer against exp_q.
  task automatic run_op(input string name, input bit rnd, output int cyc);
    int ci = 0, bi = 0, ei = 0, ai = 0;
    cyc = 0;
    msg_auth_valid = 1'b1;
    while (ei < ne && cyc < 300) begin
      do_ready        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cmd_valid       = (ci < nc);
      cmd             = (ci < nc) ? cmd_q[ci] : 32'd0;
      bdo_valid       = (bi < nb);
      bdo             = (bi < nb) ? bdo_q[bi] : 32'd0;
      bdo_valid_bytes = (bi < nb) ? vb_q[bi] : 4'b0000;
      @(negedge clk);
      if (bdo_ready && !do_ready) check({name, " bdo_ready_without_do_ready"}, 32'(bdo_ready), 32'(do_ready));
      if (do_valid && do_ready) begin
        check($sformatf("%s do_data[%0d]", name, ei), do_data, exp_q[ei]);
        check($sformatf("%s do_last[%0d]", name, ei), 32'(do_last), 32'(ei == ne - 1));
        ei++;
      end
      if (cmd_valid && cmd_ready) ci++;
      if (bdo_valid && bdo_ready) bi++;
      if (msg_auth_valid && msg_auth_ready) ai++;
      go();
      cyc++;
    end
    cmd_valid      = 1'b0;
    bdo_valid      = 1'b0;
    msg_auth_valid = 1'b0;
    do_ready       = 1'b1;
    check({name, " do_words"}, ei, ne);
    check({name, " cmd_words"}, ci, nc);
    check({name, " bdo_words"}, bi, nb);
    check({name, " auth_handshakes"}, ai, na);
  endtask

  initial begin
    rst = 1'b1;
    cmd = 32'd0; cmd_valid = 1'b0;
    bdo = 32'd0; bdo_valid = 1'b0; bdo_valid_bytes = 4'b0000;
    end_of_block = 1'b0;
    msg_auth = 1'b0; msg_auth_valid = 1'b0;
    do_ready = 1'b1;
    go(); go();
    @(negedge clk);
    check("rst do_valid", 32'(do_valid), 32'd0);
    check("rst do_last", 32'(do_last), 32'd0);
    check("rst bdo_ready", 32'(bdo_ready), 32'd0);
    check("rst msg_auth_ready", 32'(msg_auth_ready), 32'd0);
    check("rst do_data", do_data, 32'd0);
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    go();
    rst = 1'b0;

    // ENC L=5, full throughput
    cmd_q[0] = 32'h20000000; cmd_q[1] = 32'h44000005; nc = 2;
    bdo_q[0] = 32'h11223344; vb_q[0] = 4'b1111;
    bdo_q[1] = 32'h55AABBCC; vb_q[1] = 4'b1000;
    bdo_q[2] = 32'hDEADBEEF; vb_q[2] = 4'b1111;
    bdo_q[3] = 32'h01234567; vb_q[3] = 4'b1111; nb = 4;
    exp_q[0] = 32'h44000005; exp_q[1] = 32'h11223344; exp_q[2] = L5_LAST;
    exp_q[3] = 32'h83000008; exp_q[4] = 32'hDEADBEEF; exp_q[5] = 32'h01234567;
    exp_q[6] = 32'hE0000000; ne = 7; na = 0;
    msg_auth = 1'b0;
    run_op("enc_l5", 1'b0, cycles);
    check("enc_l5 cycles", cycles, 8);

    // DEC L=8, authentication fails
    cmd_q[0] = 32'h30000000; cmd_q[1] = 32'h54000008; nc = 2;
    bdo_q[0] = 32'hCAFEF00D; vb_q[0] = 4'b1111;
    bdo_q[1] = 32'h0BADBEEF; vb_q[1] = 4'b1111; nb = 2;
    exp_q[0] = 32'h54000008; exp_q[1] = 32'hCAFEF00D; exp_q[2] = 32'h0BADBEEF;
    exp_q[3] = 32'hF0000000; ne = 4; na = 1;
    msg_auth = 1'b0;
    run_op("dec_l8_bad", 1'b0, cycles);
    check("dec_l8_bad cycles", cycles, 6);

    // ENC L=0: header, tag header, two tag words, status
    cmd_q[0] = 32'h20000000; cmd_q[1] = 32'h46000000; nc = 2;
    bdo_q[0] = 32'hA5A5A5A5; vb_q[0] = 4'b1111;
    bdo_q[1] = 32'h5A5A5A5A; vb_q[1] = 4'b1111; nb = 2;
    exp_q[0] = 32'h46000000; exp_q[1] = 32'h83000008; exp_q[2] = 32'hA5A5A5A5;
    exp_q[3] = 32'h5A5A5A5A; exp_q[4] = 32'hE0000000; ne = 5; na = 0;
    run_op("enc_l0", 1'b0, cycles);
    check("enc_l0 cycles", cycles, 6);

    // ENC L=12 with random do_ready stalls
    cmd_q[0] = 32'h20000000; cmd_q[1] = 32'h4400000C; nc = 2;
    bdo_q[0] = 32'h00000001; bdo_q[1] = 32'h00000002; bdo_q[2] = 32'h00000003;
    bdo_q[3] = 32'h7E7E7E7E; bdo_q[4] = 32'h81818181; nb = 5;
    for (int i = 0; i < 5; i++) vb_q[i] = 4'b1111;
    exp_q[0] = 32'h4400000C; exp_q[1] = 32'h00000001; exp_q[2] = 32'h00000002;
    exp_q[3] = 32'h00000003; exp_q[4] = 32'h83000008; exp_q[5] = 32'h7E7E7E7E;
    exp_q[6] = 32'h81818181; exp_q[7] = 32'hE0000000; ne = 8; na = 0;
    run_op("enc_l12_stall", 1'b1, cycles);

    // Reset in TAG after one tag word
    cmd = 32'h20000000; cmd_valid = 1'b1; do_ready = 1'b1;
    go();
    cmd = 32'h46000000;
    go();
    cmd_valid = 1'b0; bdo = 32'h12345678; bdo_valid = 1'b1; bdo_valid_bytes = 4'b1111;
    @(negedge clk);
    check("rstmid tag_hdr", do_data, 32'h83000008);
    check("rstmid tag_hdr bdo_ready", 32'(bdo_ready), 32'd0);
    go();
    @(negedge clk);
    check("rstmid tag0 bdo_ready", 32'(bdo_ready), 32'd1);
    go();
    rst = 1'b1;
    go();
    rst = 1'b0; bdo_valid = 1'b0;
    @(negedge clk);
    check("rstmid do_valid", 32'(do_valid), 32'd0);
    check("rstmid cmd_ready", 32'(cmd_ready), 32'd1);
    check("rstmid bdo_ready", 32'(bdo_ready), 32'd0);
    go();

    // DEC L=4, authentication passes
    cmd_q[0] = 32'h30000000; cmd_q[1] = 32'h54000004; nc = 2;
    bdo_q[0] = 32'h600DDA7A; vb_q[0] = 4'b1111; nb = 1;
    exp_q[0] = 32'h54000004; exp_q[1] = 32'h600DDA7A; exp_q[2] = 32'hE0000000;
    ne = 3; na = 1;
    msg_auth = 1'b1;
    run_op("dec_l4_ok", 1'b0, cycles);
    check("dec_l4_ok cycles", cycles, 5);

    // Unsupported opcode
    cmd_q[0] = 32'h70000000; nc = 1; nb = 0;
    exp_q[0] = 32'hF0000000; ne = 1; na = 0;
    run_op("bad_op", 1'b0, cycles);
    check("bad_op cycles", cycles, 2);
    @(negedge clk);
    check("bad_op idle cmd_ready", 32'(cmd_ready), 32'd1);
    check("bad_op idle do_valid", 32'(do_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
